// File: rtl/rom64_if.sv
// Memory-side bus of the ROM64 test master.
// master: drives wrrd/addr/wr_data, samples rd_data; slave: the memory.
interface rom64_if;
    logic        mem_wrrd;
    logic [15:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    modport master (
        output mem_wrrd,
        output mem_addr,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_wrrd,
        input  mem_addr,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/rom64_master.sv
// Memory pattern master: writes, read-verifies or interleaves a seed+i pattern.
// Ports: clk, rst (async low), start/mode/base_addr/len/seed command,
// busy/done/err_cnt/first_err_addr status, mem bus via rom64_if.master.
module rom64_master #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] base_addr,
    input  logic [15:0] len,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic [15:0] err_cnt,
    output logic [15:0] first_err_addr,
    rom64_if.master     mem
);

    typedef enum logic [2:0] {
        IDLE, WR, RD, WR_I, RD_I, DRAIN, DONE
    } state_t;

    typedef struct packed {
        logic        v;
        logic [15:0] a;
        logic [31:0] e;
    } rd_ent_t;

    localparam logic [2:0] DRN_LAST = 3'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] ferr_q, ferr_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] pat_q, pat_d;
    logic [31:0] wd_q, wd_d;
    logic        wrrd_q, wrrd_d;
    logic [2:0]  drn_q, drn_d;
    rd_ent_t     pipe_q [RD_LAT];
    rd_ent_t     pipe_d [RD_LAT];

    logic        last;
    logic        rd_now;
    logic        mism;
    rd_ent_t     tail;

    // Read tracking: each issued read enters stage 0 and reaches the tail
    // exactly in the cycle its data is on mem_rd_data.
    always_comb begin
        rd_now = (state_q == RD) || (state_q == RD_I);
        pipe_d[0] = '{v: rd_now, a: addr_q, e: pat_q};
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
        tail = pipe_q[RD_LAT-1];
        mism = tail.v && (mem.mem_rd_data != tail.e);
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        err_cnt_d = err_cnt_q;
        ferr_d    = ferr_q;
        addr_d    = addr_q;
        pat_d     = pat_q;
        wd_d      = wd_q;
        wrrd_d    = 1'b0;
        drn_d     = drn_q;
        last      = (idx_q == len_q - 16'd1);

        if (mism) begin
            if (err_cnt_q == 16'd0) begin
                ferr_d = tail.a;
            end
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = len;
                    idx_d     = 16'd0;
                    err_cnt_d = 16'd0;
                    ferr_d    = 16'd0;
                    drn_d     = 3'd0;
                    if (len == 16'd0 || mode == 2'b11) begin
                        state_d = DONE;
                    end else begin
                        addr_d = base_addr;
                        pat_d  = seed;
                        if (mode == 2'b01) begin
                            state_d = RD;
                        end else begin
                            state_d = (mode == 2'b00) ? WR : WR_I;
                            wrrd_d  = 1'b1;
                            wd_d    = seed;
                        end
                    end
                end
            end
            WR: begin
                if (last) begin
                    state_d = DONE;
                end else begin
                    idx_d  = idx_q + 16'd1;
                    addr_d = addr_q + 16'd1;
                    pat_d  = pat_q + 32'd1;
                    wd_d   = pat_q + 32'd1;
                    wrrd_d = 1'b1;
                end
            end
            RD: begin
                if (last) begin
                    state_d = DRAIN;
                    drn_d   = 3'd0;
                end else begin
                    idx_d  = idx_q + 16'd1;
                    addr_d = addr_q + 16'd1;
                    pat_d  = pat_q + 32'd1;
                end
            end
            // Read back the word just written: address and pattern unchanged.
            WR_I: begin
                state_d = RD_I;
            end
            RD_I: begin
                if (last) begin
                    state_d = DRAIN;
                    drn_d   = 3'd0;
                end else begin
                    state_d = WR_I;
                    idx_d   = idx_q + 16'd1;
                    addr_d  = addr_q + 16'd1;
                    pat_d   = pat_q + 32'd1;
                    wd_d    = pat_q + 32'd1;
                    wrrd_d  = 1'b1;
                end
            end
            DRAIN: begin
                if (drn_q == DRN_LAST) begin
                    state_d = DONE;
                end else begin
                    drn_d = drn_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            err_cnt_q <= '0;
            ferr_q    <= '0;
            addr_q    <= '0;
            pat_q     <= '0;
            wd_q      <= '0;
            wrrd_q    <= 1'b0;
            drn_q     <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            err_cnt_q <= err_cnt_d;
            ferr_q    <= ferr_d;
            addr_q    <= addr_d;
            pat_q     <= pat_d;
            wd_q      <= wd_d;
            wrrd_q    <= wrrd_d;
            drn_q     <= drn_d;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign err_cnt         = err_cnt_q;
    assign first_err_addr  = ferr_q;
    assign mem.mem_wrrd    = wrrd_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_wr_data = wd_q;

endmodule
